// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, local bubble
// insertion on load-use or branch flush, and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  branch_in,
  input  logic                  memread_in,
  input  logic                  memtoreg_in,
  input  logic                  memwrite_in,
  input  logic                  alusrc_in,
  input  logic                  regwrite_in,
  input  logic [1:0]            aluop_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     rd1_in,
  input  logic [DATA_W-1:0]     rd2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [3:0]            funct_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  branch_out,
  output logic                  memread_out,
  output logic                  memtoreg_out,
  output logic                  memwrite_out,
  output logic                  alusrc_out,
  output logic                  regwrite_out,
  output logic [1:0]            aluop_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     rd1_out,
  output logic [DATA_W-1:0]     rd2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [3:0]            funct_out,
  output logic [REG_ADDR_W-1:0] rs1_out,
  output logic [REG_ADDR_W-1:0] rs2_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_control_mux,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hazard;
  logic go;

  // x0 is never a real producer, so a load to x0 must not stall.
  assign hazard = memread_out && (rd_out != '0) &&
                  ((rd_out == rs1_in) || (rd_out == rs2_in));

  // A flush overrides the stall so the redirect target can load.
  assign go               = flush | ~hazard;
  assign pc_write         = go;
  assign ifid_write       = go;
  assign idex_control_mux = go;

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_out   <= 1'b0;
      memread_out  <= 1'b0;
      memtoreg_out <= 1'b0;
      memwrite_out <= 1'b0;
      alusrc_out   <= 1'b0;
      regwrite_out <= 1'b0;
      aluop_out    <= '0;
      pc_out       <= '0;
      rd1_out      <= '0;
      rd2_out      <= '0;
      imm_out      <= '0;
      funct_out    <= '0;
      rs1_out      <= '0;
      rs2_out      <= '0;
      rd_out       <= '0;
      bubble_count <= '0;
    end else if (flush || hazard) begin
      // Bubble is zeroed here rather than trusting the control-unit mux.
      branch_out   <= 1'b0;
      memread_out  <= 1'b0;
      memtoreg_out <= 1'b0;
      memwrite_out <= 1'b0;
      alusrc_out   <= 1'b0;
      regwrite_out <= 1'b0;
      aluop_out    <= '0;
      pc_out       <= '0;
      rd1_out      <= '0;
      rd2_out      <= '0;
      imm_out      <= '0;
      funct_out    <= '0;
      rs1_out      <= '0;
      rs2_out      <= '0;
      rd_out       <= '0;
      if (!flush && (bubble_count != CNT_MAX))
        bubble_count <= bubble_count + CNT_W'(1);
    end else begin
      branch_out   <= branch_in;
      memread_out  <= memread_in;
      memtoreg_out <= memtoreg_in;
      memwrite_out <= memwrite_in;
      alusrc_out   <= alusrc_in;
      regwrite_out <= regwrite_in;
      aluop_out    <= aluop_in;
      pc_out       <= pc_in;
      rd1_out      <= rd1_in;
      rd2_out      <= rd2_in;
      imm_out      <= imm_in;
      funct_out    <= funct_in;
      rs1_out      <= rs1_in;
      rs2_out      <= rs2_in;
      rd_out       <= rd_in;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed plus random instruction streams, expected
// EX contents and stall outputs queued by a reference model, popped by monitors.
module tb_id_ex_stage;
  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic          branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]    aluop;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [3:0]    funct;
    logic [AW-1:0] rs1, rs2, rd;
  } ins_t;

  typedef struct packed {
    ins_t          ex;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic branch_in, memread_in, memtoreg_in, memwrite_in, alusrc_in, regwrite_in;
  logic [1:0] aluop_in;
  logic [DW-1:0] pc_in, rd1_in, rd2_in, imm_in;
  logic [3:0] funct_in;
  logic [AW-1:0] rs1_in, rs2_in, rd_in;
  logic branch_out, memread_out, memtoreg_out, memwrite_out, alusrc_out, regwrite_out;
  logic [1:0] aluop_out;
  logic [DW-1:0] pc_out, rd1_out, rd2_out, imm_out;
  logic [3:0] funct_out;
  logic [AW-1:0] rs1_out, rs2_out, rd_out;
  logic pc_write, ifid_write, idex_control_mux;
  logic [CW-1:0] bubble_count;

  id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .branch_in(branch_in), .memread_in(memread_in), .memtoreg_in(memtoreg_in),
    .memwrite_in(memwrite_in), .alusrc_in(alusrc_in), .regwrite_in(regwrite_in),
    .aluop_in(aluop_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .imm_in(imm_in), .funct_in(funct_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rd_in(rd_in),
    .branch_out(branch_out), .memread_out(memread_out), .memtoreg_out(memtoreg_out),
    .memwrite_out(memwrite_out), .alusrc_out(alusrc_out), .regwrite_out(regwrite_out),
    .aluop_out(aluop_out), .pc_out(pc_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .imm_out(imm_out), .funct_out(funct_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rd_out(rd_out), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_control_mux(idex_control_mux), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  exp_t       reg_q[$];
  logic [2:0] stall_q[$];
  int n_vec = 0, n_cmp = 0, n_err = 0;

  // Reference model: the instruction occupying EX and the bubble tally.
  ins_t m_ex = '0;
  int   m_cnt = 0;

  exp_t act;
  assign act = '{ex: '{branch: branch_out, memread: memread_out, memtoreg: memtoreg_out,
                       memwrite: memwrite_out, alusrc: alusrc_out, regwrite: regwrite_out,
                       aluop: aluop_out, pc: pc_out, rd1: rd1_out, rd2: rd2_out,
                       imm: imm_out, funct: funct_out, rs1: rs1_out, rs2: rs2_out,
                       rd: rd_out},
                 cnt: bubble_count};

  always @(negedge clk) begin
    if (stall_q.size() != 0) begin
      logic [2:0] e;
      e = stall_q.pop_front();
      n_cmp++;
      if ({pc_write, ifid_write, idex_control_mux} !== e) begin
        n_err++;
        $display("FAIL stall: got %b want %b at %0t",
                 {pc_write, ifid_write, idex_control_mux}, e, $time);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reg_q.size() != 0) begin
      exp_t e;
      e = reg_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL ex_regs: got cnt=%0d ex=%h want cnt=%0d ex=%h at %0t",
                 act.cnt, act.ex, e.cnt, e.ex, $time);
      end
    end
  end

  task automatic drive(input ins_t d, input logic f, input logic r);
    bit hz;
    exp_t e;
    @(posedge clk);
    #2;
    reset = r; flush = f;
    branch_in = d.branch; memread_in = d.memread; memtoreg_in = d.memtoreg;
    memwrite_in = d.memwrite; alusrc_in = d.alusrc; regwrite_in = d.regwrite;
    aluop_in = d.aluop; pc_in = d.pc; rd1_in = d.rd1; rd2_in = d.rd2;
    imm_in = d.imm; funct_in = d.funct; rs1_in = d.rs1; rs2_in = d.rs2; rd_in = d.rd;
    n_vec++;
    // A load in EX whose nonzero destination is read by the decoding instruction.
    hz = m_ex.memread && (m_ex.rd != 0) && (m_ex.rd == d.rs1 || m_ex.rd == d.rs2);
    stall_q.push_back((f || !hz) ? 3'b111 : 3'b000);
    if (!r) begin
      m_ex = '0; m_cnt = 0;
    end else if (f) begin
      m_ex = '0;
    end else if (hz) begin
      m_ex = '0;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else begin
      m_ex = d;
    end
    e.ex = m_ex;
    e.cnt = CW'(m_cnt);
    reg_q.push_back(e);
  endtask

  function automatic ins_t rand_ins();
    ins_t d;
    d.branch = 1'($urandom); d.memread = 1'($urandom); d.memtoreg = 1'($urandom);
    d.memwrite = 1'($urandom); d.alusrc = 1'($urandom); d.regwrite = 1'($urandom);
    d.aluop = 2'($urandom);
    d.pc = {$urandom, $urandom}; d.rd1 = {$urandom, $urandom};
    d.rd2 = {$urandom, $urandom}; d.imm = {$urandom, $urandom};
    d.funct = 4'($urandom);
    d.rs1 = AW'($urandom_range(0, 3)); d.rs2 = AW'($urandom_range(0, 3));
    d.rd = AW'($urandom_range(0, 3));
    return d;
  endfunction

  function automatic ins_t mk(input logic mr, input logic rw, input logic [1:0] op,
                              input int a, input int b, input int rs1, input int rs2,
                              input int rd);
    ins_t d;
    d = '0;
    d.memread = mr; d.memtoreg = mr; d.regwrite = rw; d.aluop = op;
    d.alusrc = mr;
    d.pc = 64'h1000 + DW'(rd * 4); d.rd1 = DW'(a); d.rd2 = DW'(b); d.imm = DW'(8);
    d.rs1 = AW'(rs1); d.rs2 = AW'(rs2); d.rd = AW'(rd);
    return d;
  endfunction

  initial begin
    ins_t add_i, ld5, dep5, ld0, ldd;
    add_i = mk(1'b0, 1'b1, 2'b10, 5, 7, 1, 2, 3);
    ld5   = mk(1'b1, 1'b1, 2'b00, 0, 0, 2, 0, 5);
    dep5  = mk(1'b0, 1'b1, 2'b10, 9, 4, 5, 6, 7);
    ld0   = mk(1'b1, 1'b1, 2'b00, 0, 0, 1, 0, 0);
    ldd   = mk(1'b1, 1'b1, 2'b00, 0, 0, 5, 0, 5);

    // Reset held with nonzero inputs, then release.
    drive(add_i, 1'b0, 1'b0);
    drive(add_i, 1'b0, 1'b0);
    drive(add_i, 1'b0, 1'b1);
    drive(add_i, 1'b0, 1'b1);
    // Load-use: bubble, then the held dependent instruction latches.
    drive(ld5, 1'b0, 1'b1);
    drive(dep5, 1'b0, 1'b1);
    drive(dep5, 1'b0, 1'b1);
    // Load to x0 read by x0: never stalls.
    drive(ld0, 1'b0, 1'b1);
    drive(mk(1'b0, 1'b1, 2'b10, 1, 1, 0, 0, 4), 1'b0, 1'b1);
    // Flush while the hazard condition holds.
    drive(ld5, 1'b0, 1'b1);
    drive(dep5, 1'b1, 1'b1);
    // Dependent back-to-back loads drive the counter into saturation.
    drive(ld5, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(ldd, 1'b0, 1'b1);
    // Reset taking effect mid-stall.
    drive(ld5, 1'b0, 1'b1);
    drive(dep5, 1'b0, 1'b0);
    drive(dep5, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++)
      drive(rand_ins(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) != 0));

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (reg_q.size() != 0 || stall_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d left want 0/0", reg_q.size(), stall_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core. Sits directly downstream of the decode control unit and register file.
- Latches the decoded control bundle, operands, immediate and register indices into EX.
- Contains the load-use hazard detector. It drives the stall signals, including the control-mux select that forces the control unit to emit a NOP.
- Inserts bubbles on load-use and on branch flush. Counts hazard bubbles for performance debug.

Parameters:
DATA_W, 64, operand/PC/immediate width
REG_ADDR_W, 5, register index width
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  branch taken, resolved downstream; squash the instruction entering EX
branch_in  in  1  control from decode
memread_in  in  1  control from decode
memtoreg_in  in  1  control from decode
memwrite_in  in  1  control from decode
alusrc_in  in  1  control from decode
regwrite_in  in  1  control from decode
aluop_in  in  2  control from decode
pc_in  in  DATA_W  PC of decoding instruction
rd1_in  in  DATA_W  register file read data 1
rd2_in  in  DATA_W  register file read data 2
imm_in  in  DATA_W  sign-extended immediate
funct_in  in  4  {funct7[5], funct3}
rs1_in  in  REG_ADDR_W  source 1 index of decoding instruction
rs2_in  in  REG_ADDR_W  source 2 index of decoding instruction
rd_in  in  REG_ADDR_W  destination index
branch_out, memread_out, memtoreg_out, memwrite_out, alusrc_out, regwrite_out  out  1 each  registered controls
aluop_out  out  2  registered ALUop
pc_out, rd1_out, rd2_out, imm_out  out  DATA_W each  registered data
funct_out  out  4  registered funct
rs1_out, rs2_out, rd_out  out  REG_ADDR_W each  registered indices (feed forwarding unit)
pc_write  out  1  0 = hold PC
ifid_write  out  1  0 = hold IF/ID register
idex_control_mux  out  1  0 = control unit outputs NOP
bubble_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (reset==0 at a rising edge): all registered outputs go to 0, including bubble_count. Reset wins over flush and hazard, and takes effect mid-stall.
- Hazard detection is combinational from registered state and current inputs:
  - hazard = memread_out & (rd_out != 0) & ((rd_out == rs1_in) | (rd_out == rs2_in)).
  - Destination x0 never causes a hazard.
- Stall outputs:
  - If flush==1: pc_write = ifid_write = idex_control_mux = 1. The flush target must load.
  - Otherwise: pc_write = ifid_write = idex_control_mux = ~hazard.
- Register update on each rising edge with reset==1, in priority order:
  1. flush: load a bubble, i.e. all controls, aluop, rd/rs1/rs2, data and funct set to 0. bubble_count unchanged.
  2. hazard: load a bubble. bubble_count increments by 1, saturating at 2^CNT_W-1 (no wrap).
  3. Else: load all *_in onto the matching *_out.
- Bubble forcing is local. The stage zeroes controls itself and does not rely on the control unit honouring idex_control_mux.
- Latency: 1 cycle from input to output.
- Load-use stall is exactly one cycle. After a bubble is loaded, memread_out is 0, so hazard clears. The held instruction then enters EX on the next edge.
- Back-to-back loads with a dependency produce one bubble per dependent pair, never two consecutive.
- Stores/branches using rs2 are treated like any rs2 consumer (conservative stall).

Test Plan:
- Reset: hold reset=0 for 2 cycles with nonzero inputs -> every output 0, bubble_count=0; release reset -> next edge outputs equal inputs.
- Pass-through: add x3,x1,x2 (regwrite=1, aluop=2'b10, rd1=5, rd2=7, rd=3) -> after 1 edge regwrite_out=1, aluop_out=2'b10, rd1_out=5, rd2_out=7, rd_out=3; stall outputs all 1.
- Load-use: ld x5 in EX (memread_out=1, rd_out=5), decoding rs1_in=5 -> pc_write=ifid_write=idex_control_mux=0. Next edge: all controls 0, bubble_count=1. Following cycle: stall outputs 1 and the dependent instruction latches.
- x0 destination: memread_out=1, rd_out=0, rs1_in=0 -> no stall, bubble_count unchanged.
- Flush with hazard: hazard condition true and flush=1 -> stall outputs 1. Next edge: bubble loaded, bubble_count unchanged.
- Saturation with CNT_W=2: force 5 load-use stalls -> bubble_count reads 1,2,3,3,3.
